hdmi_read_sched: RTL and testbench

Frame-read scheduler that sits between the HDMI output core's read-pacing pulses (`read_go`, `read_next_line`, `read_next_chunk`, `read_done`) and the memory read master feeding the pixel FIFO. It turns each pulse into fixed-size burst read requests at the correct framebuffer address, and keeps at most one line's worth of chunks per line. It also owns front/back framebuffer selection, swapping only at frame boundaries on request from the renderer.

---
 rtl/hdmi_read_sched_if.sv | 22 ++
 rtl/hdmi_read_sched.sv | 188 ++++++++++++++++++
 tb/tb_hdmi_read_sched.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_read_sched_if.sv
// Burst read request channel between the frame-read scheduler and the memory read master.
// The scheduler holds rd_req/rd_addr until the master accepts with rd_ack.
interface hdmi_read_sched_if;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [7:0]  rd_len;
  logic        rd_ack;

  modport master (
    output rd_req,
    output rd_addr,
    output rd_len,
    input  rd_ack
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    input  rd_len,
    output rd_ack
  );
endinterface

// File: rtl/hdmi_read_sched.sv
// Frame-read scheduler: turns HDMI read-pacing pulses into fixed-size burst requests
// at framebuffer addresses and swaps front/back buffers only at frame end.
module hdmi_read_sched #(
  parameter int NUM_BYTES_PER_PIXEL = 4,
  parameter int CHUNK_PIXELS        = 64,
  parameter int PREFETCH_CHUNKS     = 2,
  parameter int MAX_PENDING         = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [10:0]              hres,
  input  logic [31:0]              fb_base_a,
  input  logic [31:0]              fb_base_b,
  input  logic                     swap_req,
  input  logic                     read_go,
  input  logic                     read_next_line,
  input  logic                     read_next_chunk,
  input  logic                     read_done,
  hdmi_read_sched_if.master        rd,
  output logic                     front_sel,
  output logic                     swap_done,
  output logic                     overrun,
  output logic                     late_line
);

  localparam int         BURST_BYTES = CHUNK_PIXELS * NUM_BYTES_PER_PIXEL;
  localparam int         CNT_W       = 12;
  localparam int         PEND_W      = $clog2(MAX_PENDING + 1);
  localparam logic [7:0] RD_LEN      = 8'(BURST_BYTES / 4);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t             state_q, state_d;
  logic [PEND_W-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   cpl_q, cpl_d;
  logic [31:0]        stride_q, stride_d;
  logic [31:0]        line_base_q, line_base_d;
  logic [31:0]        next_addr_q, next_addr_d;
  logic [31:0]        frame_base;
  logic [PEND_W:0]    pend_sum;
  logic               rd_req_q, rd_req_d;
  logic               swap_pending_q, swap_pending_d;
  logic               front_sel_d, swap_done_d, overrun_d, late_line_d;
  logic               accept, start, ovf, room;

  // Saturating add into the pending counter; MSB of the result flags a dropped increment.
  function automatic logic [PEND_W:0] sat_add(input logic [PEND_W-1:0] base,
                                              input logic [PEND_W-1:0] inc);
    logic [PEND_W:0] s;
    s = {1'b0, base} + {1'b0, inc};
    if (s > (PEND_W+1)'(MAX_PENDING))
      return {1'b1, PEND_W'(MAX_PENDING)};
    return {1'b0, s[PEND_W-1:0]};
  endfunction

  function automatic logic [CNT_W-1:0] chunks_of(input logic [10:0] h);
    logic [31:0] q;
    q = ({21'd0, h} + 32'(CHUNK_PIXELS - 1)) / 32'(CHUNK_PIXELS);
    return q[CNT_W-1:0];
  endfunction

  function automatic logic [PEND_W-1:0] prefetch_of(input logic [CNT_W-1:0] cpl);
    if (cpl < CNT_W'(PREFETCH_CHUNKS))
      return PEND_W'(cpl);
    return PEND_W'(PREFETCH_CHUNKS);
  endfunction

  assign accept     = rd_req_q && rd.rd_ack;
  assign frame_base = front_sel ? fb_base_b : fb_base_a;
  assign room       = (issued_q + CNT_W'(pending_q)) < cpl_q;

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    issued_d       = issued_q;
    cpl_d          = cpl_q;
    stride_d       = stride_q;
    line_base_d    = line_base_q;
    next_addr_d    = next_addr_q;
    front_sel_d    = front_sel;
    swap_pending_d = swap_pending_q | swap_req;
    swap_done_d    = 1'b0;
    late_line_d    = late_line;
    pend_sum       = '0;
    ovf            = 1'b0;
    start          = 1'b0;

    if (accept) begin
      next_addr_d = next_addr_q + 32'(BURST_BYTES);
      issued_d    = issued_q + CNT_W'(1);
      pending_d   = pending_q - PEND_W'(1);
    end

    unique case (state_q)
      IDLE: start = read_go;
      ACTIVE: begin
        if (read_done) begin
          pending_d = '0;
          state_d   = IDLE;
          if (swap_pending_q || swap_req) begin
            front_sel_d    = ~front_sel;
            swap_pending_d = 1'b0;
            swap_done_d    = 1'b1;
          end
        end else if (read_go) begin
          start = 1'b1;
        end else if (read_next_line) begin
          if (pending_q != '0)
            late_line_d = 1'b1;
          line_base_d = line_base_q + stride_q;
          next_addr_d = line_base_q + stride_q;
          issued_d    = '0;
          pend_sum    = sat_add('0, prefetch_of(cpl_q));
          pending_d   = pend_sum[PEND_W-1:0];
          ovf         = pend_sum[PEND_W];
        end else if (read_next_chunk && room) begin
          // A simultaneous accept cancels the increment, so it can never overflow.
          if (accept) begin
            pending_d = pending_q;
          end else begin
            pend_sum  = sat_add(pending_q, PEND_W'(1));
            pending_d = pend_sum[PEND_W-1:0];
            ovf       = pend_sum[PEND_W];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      stride_d    = {21'd0, hres} * 32'(NUM_BYTES_PER_PIXEL);
      cpl_d       = chunks_of(hres);
      line_base_d = frame_base;
      next_addr_d = frame_base;
      issued_d    = '0;
      pend_sum    = sat_add('0, prefetch_of(chunks_of(hres)));
      pending_d   = pend_sum[PEND_W-1:0];
      ovf         = pend_sum[PEND_W];
      state_d     = ACTIVE;
    end

    overrun_d = overrun | ovf;
    rd_req_d  = (pending_d != '0);
  end

  // Control and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      issued_q       <= '0;
      next_addr_q    <= '0;
      rd_req_q       <= 1'b0;
      front_sel      <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done      <= 1'b0;
      overrun        <= 1'b0;
      late_line      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      issued_q       <= issued_d;
      next_addr_q    <= next_addr_d;
      rd_req_q       <= rd_req_d;
      front_sel      <= front_sel_d;
      swap_pending_q <= swap_pending_d;
      swap_done      <= swap_done_d;
      overrun        <= overrun_d;
      late_line      <= late_line_d;
    end
  end

  // Per-frame geometry, always reloaded at read_go before it is used
  always_ff @(posedge clock) begin
    cpl_q       <= cpl_d;
    stride_q    <= stride_d;
    line_base_q <= line_base_d;
  end

  assign rd.rd_req  = rd_req_q;
  assign rd.rd_addr = next_addr_q;
  assign rd.rd_len  = RD_LEN;

endmodule

// File: tb/tb_hdmi_read_sched.sv
// Directed bench for hdmi_read_sched: a frame/line/chunk-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_hdmi_read_sched;

  localparam int EV_GO = 0, EV_LINE = 1, EV_CHUNK = 2, EV_DONE = 3, EV_SWAP = 4;
  localparam logic [31:0] BASE_A = 32'h1000_0000;
  localparam logic [31:0] BASE_B = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [10:0] hres;
  logic [31:0] fb_base_a, fb_base_b;
  logic        swap_req, read_go, read_next_line, read_next_chunk, read_done;
  logic        front_sel, swap_done, overrun, late_line;
  logic        chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] acc_q[$];

  hdmi_read_sched_if rd_if ();

  hdmi_read_sched dut (
    .clock           (clock),
    .reset           (reset),
    .hres            (hres),
    .fb_base_a       (fb_base_a),
    .fb_base_b       (fb_base_b),
    .swap_req        (swap_req),
    .read_go         (read_go),
    .read_next_line  (read_next_line),
    .read_next_chunk (read_next_chunk),
    .read_done       (read_done),
    .rd              (rd_if.master),
    .front_sel       (front_sel),
    .swap_done       (swap_done),
    .overrun         (overrun),
    .late_line       (late_line)
  );

  always #5 clock = ~clock;

  // Model: a frame is a set of lines, each line a run of chunk bursts.
  typedef struct {
    int          pend;
    int          issued;
    int          line;
    int          cpl;
    bit          active;
    bit          front;
    bit          swpend;
    bit          swdone;
    bit          over;
    bit          late;
    logic [31:0] base;
    logic [31:0] stride;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t start_frame(input mstate_t s);
    mstate_t n = s;
    n.base   = s.front ? fb_base_b : fb_base_a;
    n.stride = 32'(int'(hres) * 4);
    n.cpl    = (int'(hres) + 63) / 64;
    n.line   = 0;
    n.issued = 0;
    n.pend   = (n.cpl < 2) ? n.cpl : 2;
    n.active = 1'b1;
    return n;
  endfunction

  function automatic mstate_t step(input mstate_t s);
    mstate_t n = s;
    bit acc;
    if (reset) begin
      n = '{default: 0};
      return n;
    end
    acc = (s.pend > 0) && rd_if.rd_ack;
    n.swdone = 1'b0;
    if (swap_req) n.swpend = 1'b1;
    if (acc) begin
      n.issued = s.issued + 1;
      n.pend   = s.pend - 1;
    end
    if (!s.active) begin
      if (read_go) n = start_frame(n);
    end else if (read_done) begin
      n.pend   = 0;
      n.active = 1'b0;
      if (s.swpend || swap_req) begin
        n.front  = !s.front;
        n.swpend = 1'b0;
        n.swdone = 1'b1;
      end
    end else if (read_go) begin
      n = start_frame(n);
    end else if (read_next_line) begin
      if (s.pend != 0) n.late = 1'b1;
      n.line   = s.line + 1;
      n.issued = 0;
      n.pend   = (s.cpl < 2) ? s.cpl : 2;
    end else if (read_next_chunk && (s.issued + s.pend < s.cpl)) begin
      if (acc) n.pend = s.pend;
      else if (s.pend == 7) n.over = 1'b1;
      else n.pend = s.pend + 1;
    end
    return n;
  endfunction

  function automatic logic [31:0] exp_addr(input mstate_t s);
    return s.base + 32'(s.line) * s.stride + 32'(s.issued) * 32'd256;
  endfunction

  always @(posedge clock) m <= step(m);

  always @(posedge clock)
    if (!reset && rd_if.rd_req && rd_if.rd_ack) acc_q.push_back(rd_if.rd_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("rd_req",    32'(rd_if.rd_req), 32'(m.pend > 0));
      check("rd_len",    32'(rd_if.rd_len), 32'd64);
      check("front_sel", 32'(front_sel),    32'(m.front));
      check("swap_done", 32'(swap_done),    32'(m.swdone));
      check("overrun",   32'(overrun),      32'(m.over));
      check("late_line", 32'(late_line),    32'(m.late));
      if (m.pend > 0) check("rd_addr", rd_if.rd_addr, exp_addr(m));
    end
  end

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_q.size()) return acc_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse(input int ev);
    case (ev)
      EV_GO:    read_go         = 1'b1;
      EV_LINE:  read_next_line  = 1'b1;
      EV_CHUNK: read_next_chunk = 1'b1;
      EV_DONE:  read_done       = 1'b1;
      default:  swap_req        = 1'b1;
    endcase
    @(negedge clock);
    read_go = 1'b0; read_next_line = 1'b0; read_next_chunk = 1'b0;
    read_done = 1'b0; swap_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; hres = 11'd800; fb_base_a = BASE_A; fb_base_b = BASE_B;
    swap_req = 1'b0; read_go = 1'b0; read_next_line = 1'b0;
    read_next_chunk = 1'b0; read_done = 1'b0; rd_if.rd_ack = 1'b1;
    @(negedge clock);
    chk_en = 1'b1;
    tick(2);
    check("rst_rd_req", 32'(rd_if.rd_req), 32'd0);
    check("rst_rd_addr", rd_if.rd_addr, 32'd0);
    reset = 1'b0;
    tick(1);

    // Single line at 800 px: 2 prefetch + 11 chunks = 13 bursts
    acc_q.delete();
    pulse(EV_GO);
    for (int i = 0; i < 11; i++) pulse(EV_CHUNK);
    tick(5);
    check("l800_count", 32'(acc_q.size()), 32'd13);
    check("l800_first", acc_at(0), 32'h1000_0000);
    check("l800_last", acc_at(12), 32'h1000_0C00);
    pulse(EV_CHUNK);
    tick(5);
    check("l800_extra", 32'(acc_q.size()), 32'd13);
    pulse(EV_DONE);

    // Line advance at 1280 px
    hres = 11'd1280;
    pulse(EV_GO);
    tick(4);
    acc_q.delete();
    pulse(EV_LINE);
    tick(4);
    check("l1280_count", 32'(acc_q.size()), 32'd2);
    check("l1280_addr0", acc_at(0), 32'h1000_1400);
    check("l1280_addr1", acc_at(1), 32'h1000_1500);
    check("l1280_late", 32'(late_line), 32'd0);
    pulse(EV_DONE);

    // Backpressure and overrun at 800 px
    hres = 11'd800;
    rd_if.rd_ack = 1'b0;
    pulse(EV_GO);
    for (int i = 0; i < 5; i++) pulse(EV_CHUNK);
    tick(1);
    check("bp_req", 32'(rd_if.rd_req), 32'd1);
    check("bp_addr", rd_if.rd_addr, 32'h1000_0000);
    check("bp_no_ovr", 32'(overrun), 32'd0);
    pulse(EV_CHUNK);
    check("bp_ovr", 32'(overrun), 32'd1);
    acc_q.delete();
    rd_if.rd_ack = 1'b1;
    tick(7);
    check("bp_drain", 32'(acc_q.size()), 32'd7);
    check("bp_last", acc_at(6), 32'h1000_0600);
    check("bp_idle", 32'(rd_if.rd_req), 32'd0);

    // Chunk pulse coinciding with an accept leaves pending unchanged
    rd_if.rd_ack = 1'b0;
    pulse(EV_CHUNK);
    pulse(EV_CHUNK);
    acc_q.delete();
    rd_if.rd_ack = 1'b1;
    read_next_chunk = 1'b1;
    @(negedge clock);
    read_next_chunk = 1'b0;
    tick(4);
    check("sim_count", 32'(acc_q.size()), 32'd3);
    check("sim_first", acc_at(0), 32'h1000_0700);
    check("sim_last", acc_at(2), 32'h1000_0900);

    // Line pulse with 3 pending: late_line, prefetch restarts at next line
    rd_if.rd_ack = 1'b0;
    for (int i = 0; i < 3; i++) pulse(EV_CHUNK);
    pulse(EV_LINE);
    check("late_set", 32'(late_line), 32'd1);
    check("late_addr", rd_if.rd_addr, 32'h1000_0C80);
    acc_q.delete();
    rd_if.rd_ack = 1'b1;
    tick(4);
    check("late_pend2", 32'(acc_q.size()), 32'd2);
    pulse(EV_DONE);

    // Swap at frame end, then a double request yields one toggle
    pulse(EV_GO);
    pulse(EV_SWAP);
    tick(2);
    check("sw_before", 32'(front_sel), 32'd0);
    pulse(EV_DONE);
    check("sw_front", 32'(front_sel), 32'd1);
    check("sw_pulse", 32'(swap_done), 32'd1);
    tick(1);
    check("sw_pulse_end", 32'(swap_done), 32'd0);
    acc_q.delete();
    pulse(EV_GO);
    tick(3);
    check("sw_base_b", acc_at(0), BASE_B);
    pulse(EV_SWAP);
    tick(1);
    pulse(EV_SWAP);
    pulse(EV_DONE);
    check("sw2_front", 32'(front_sel), 32'd0);
    acc_q.delete();
    pulse(EV_GO);
    tick(3);
    check("sw2_base_a", acc_at(0), BASE_A);
    pulse(EV_DONE);
    tick(1);
    check("sw2_once", 32'(front_sel), 32'd0);

    // Reset mid-burst with front=B and a swap pending
    pulse(EV_GO);
    pulse(EV_SWAP);
    pulse(EV_DONE);
    rd_if.rd_ack = 1'b0;
    pulse(EV_GO);
    pulse(EV_CHUNK);
    pulse(EV_CHUNK);
    pulse(EV_SWAP);
    tick(1);
    check("pre_rst_req", 32'(rd_if.rd_req), 32'd1);
    check("pre_rst_front", 32'(front_sel), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("rst2_req", 32'(rd_if.rd_req), 32'd0);
    check("rst2_addr", rd_if.rd_addr, 32'd0);
    check("rst2_front", 32'(front_sel), 32'd0);
    check("rst2_ovr", 32'(overrun), 32'd0);
    check("rst2_late", 32'(late_line), 32'd0);
    check("rst2_swdone", 32'(swap_done), 32'd0);
    reset = 1'b0;
    rd_if.rd_ack = 1'b1;
    acc_q.delete();
    pulse(EV_GO);
    tick(3);
    check("rst2_count", 32'(acc_q.size()), 32'd2);
    check("rst2_base", acc_at(0), BASE_A);
    pulse(EV_DONE);
    tick(1);
    check("rst2_noswap", 32'(front_sel), 32'd0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
